// File: rtl/clock_pkg.sv
// Select encodings shared between the front-panel set controller and the clock core.
package clock_pkg;

  localparam int SEL_W = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_RUN  = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } sel_e;

  // RUN -> SEC -> MIN -> HOUR -> RUN
  function automatic sel_e sel_next(input sel_e s);
    return sel_e'(s + 2'd1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button cleanup: 2-flop synchronizer, stability debounce, registered rise pulse.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [1:0]    warm;
  logic          primed;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      warm   <= 2'b00;
      primed <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
      // A button held through reset must be seen released before it can produce an event.
      if (warm[1] && !sync2) primed <= 1'b1;
      if (sync2 == level || accept) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
      if (accept) level <= sync2;
      rise <= accept && sync2 && primed;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel time-setting controller: MODE steps the field selector, INC emits
// single-cycle increment pulses with hold-to-repeat, idle timeout returns to RUN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000,
  parameter int IDLE_TIMEOUT    = 500000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [SEL_W-1:0] select,
  output logic             increment,
  output logic             setting
);

  localparam int NUM_BTN = 2;
  localparam int B_MODE  = 0;
  localparam int B_INC   = 1;
  localparam int RW      = $clog2(REPEAT_DELAY);
  localparam int IW      = $clog2(IDLE_TIMEOUT);

  logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_rise;

  assign btn_raw = {btn_inc, btn_mode};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[b]),
      .level (btn_lvl[b]),
      .rise  (btn_rise[b])
    );
  end

  sel_e          sel_q, sel_d;
  logic          inc_q, inc_d;
  logic          armed_q, armed_d;
  logic          phase_q, phase_d;   // 0: waiting REPEAT_DELAY, 1: REPEAT_PERIOD cadence
  logic [RW-1:0] rep_q, rep_d, rep_lim;
  logic [IW-1:0] idle_q, idle_d;
  logic          in_set, timeout, mode_ev, inc_ev, inc_lvl, rep_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= SEL_RUN;
      inc_q   <= 1'b0;
      armed_q <= 1'b0;
      phase_q <= 1'b0;
      rep_q   <= '0;
      idle_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      inc_q   <= inc_d;
      armed_q <= armed_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    in_set   = (sel_q != SEL_RUN);
    inc_lvl  = btn_lvl[B_INC];
    mode_ev  = btn_rise[B_MODE] && btn_lvl[B_MODE];
    inc_ev   = btn_rise[B_INC] && inc_lvl;
    timeout  = in_set && (idle_q == IW'(IDLE_TIMEOUT - 1));
    rep_lim  = phase_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    rep_fire = armed_q && inc_lvl && (rep_q == rep_lim) && !inc_q;

    sel_d   = sel_q;
    inc_d   = 1'b0;
    armed_d = armed_q;
    phase_d = phase_q;
    rep_d   = rep_q;
    idle_d  = in_set ? idle_q + IW'(1) : '0;

    if (armed_q) begin
      if (!inc_lvl) begin
        armed_d = 1'b0;
        rep_d   = '0;
      end else if (rep_q != rep_lim) begin
        rep_d = rep_q + RW'(1);
      end
    end

    // Priority: timeout, then MODE, then fresh INC press, then auto-repeat.
    if (timeout) begin
      sel_d   = SEL_RUN;
      armed_d = 1'b0;
      rep_d   = '0;
      idle_d  = '0;
    end else if (mode_ev) begin
      sel_d   = sel_next(sel_q);
      armed_d = 1'b0;
      rep_d   = '0;
      idle_d  = '0;
    end else if (inc_ev && in_set) begin
      inc_d   = 1'b1;
      armed_d = 1'b1;
      phase_d = 1'b0;
      rep_d   = '0;
      idle_d  = '0;
    end else if (rep_fire && in_set) begin
      inc_d   = 1'b1;
      phase_d = 1'b1;
      rep_d   = '0;
      idle_d  = '0;
    end
  end

  always_comb begin
    select    = sel_q;
    increment = inc_q;
    setting   = (sel_q != SEL_RUN);
  end

endmodule
